// File: rtl/pe_ser_pkg.sv
// Shared constants and helpers for the PE row serializer.
// The lane mux selects lane k with sel = 31-k.
package pe_ser_pkg;

  localparam int LANES = 32;
  localparam int SEL_W = 5;
  localparam int CNT_W = 6;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic sel_t lane2sel(input sel_t k);
    return SEL_W'(LANES - 1) - k;
  endfunction

  // Counts above a full row are saturated to a full row.
  function automatic cnt_t clamp_cnt(input cnt_t c);
    return (c > CNT_W'(LANES)) ? CNT_W'(LANES) : c;
  endfunction

endpackage

// File: rtl/pe_row_buf.sv
// One ping-pong entry: a captured row, its lane count and an occupancy flag.
// Load and free never target the same entry in one cycle.
module pe_row_buf
  import pe_ser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   free_i,
  input  logic [WIDTH*LANES-1:0] data_i,
  input  logic [CNT_W-1:0]       cnt_i,
  output logic [WIDTH*LANES-1:0] data_o,
  output logic [CNT_W-1:0]       cnt_o,
  output logic                   full_o
);

  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (free_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      data_d = data_i;
      cnt_d  = cnt_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign full_o = full_q;

endmodule

// File: rtl/pe_row_serializer.sv
// Streams whole rows lane-by-lane into the 32:1 PE lane mux, double-buffering
// so the next row loads while the current one is emitted.
module pe_row_serializer
  import pe_ser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LANES-1:0] in_data,
  input  logic [CNT_W-1:0]       in_count,
  output logic [WIDTH*LANES-1:0] mux_in,
  output logic [SEL_W-1:0]       mux_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  logic                   wrPtr_q, wrPtr_d;
  logic                   rdPtr_q, rdPtr_d;
  logic [SEL_W-1:0]       idx_q, idx_d;

  logic [1:0]             full;
  logic [1:0]             loadVec;
  logic [1:0]             freeVec;
  logic [WIDTH*LANES-1:0] rowData [2];
  logic [CNT_W-1:0]       rowCnt  [2];

  logic [CNT_W-1:0]       cntClamped;
  logic [CNT_W-1:0]       curCnt;
  logic                   accept;
  logic                   loadRow;
  logic                   beat;
  logic                   atLast;
  logic                   lastBeat;

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready   = !rst && !full[wrPtr_q];
  assign accept     = in_valid && in_ready;
  assign cntClamped = clamp_cnt(in_count);
  assign loadRow    = accept && (cntClamped != '0);
  assign loadVec    = {loadRow && wrPtr_q, loadRow && !wrPtr_q};

  assign curCnt    = rowCnt[rdPtr_q];
  assign atLast    = ({1'b0, idx_q} == (curCnt - CNT_W'(1)));
  assign out_valid = !rst && full[rdPtr_q];
  assign out_last  = out_valid && atLast;
  assign beat      = out_valid && out_ready;
  assign lastBeat  = beat && atLast;
  assign freeVec   = {lastBeat && rdPtr_q, lastBeat && !rdPtr_q};

  assign mux_in  = rowData[rdPtr_q];
  assign mux_sel = lane2sel(idx_q);
  assign busy    = |full;

  for (genvar g = 0; g < 2; g++) begin : gBuf
    pe_row_buf #(
      .WIDTH(WIDTH)
    ) uBuf (
      .clk    (clk),
      .rst    (rst),
      .load_i (loadVec[g]),
      .free_i (freeVec[g]),
      .data_i (in_data),
      .cnt_i  (cntClamped),
      .data_o (rowData[g]),
      .cnt_o  (rowCnt[g]),
      .full_o (full[g])
    );
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    idx_d   = idx_q;
    if (loadRow) begin
      wrPtr_d = !wrPtr_q;
    end
    if (lastBeat) begin
      idx_d   = '0;
      rdPtr_d = !rdPtr_q;
    end else if (beat) begin
      idx_d = idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_pe_row_serializer.sv
// Scoreboard bench for pe_row_serializer: a 32:1 lane mux model on mux_in/mux_sel,
// expected beats queued at row acceptance and checked by an independent monitor.
module tb_pe_row_serializer;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] word;
    logic [4:0]   sel;
    logic         last;
  } beat_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W*32-1:0] in_data;
  logic [5:0]      in_count;
  logic [W*32-1:0] mux_in;
  logic [4:0]      mux_sel;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;

  logic [4:0]      laneSel;
  logic [W-1:0]    muxOut;

  beat_t expQ[$];
  int    beatLog[$];
  int    checkCount = 0;
  int    passCount  = 0;
  int    beatsSeen  = 0;
  int    cycle      = 0;

  pe_row_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .mux_in    (mux_in),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  // 32:1 lane mux driven by the DUT: sel s picks lane 31-s.
  assign laneSel = 5'd31 - mux_sel;
  assign muxOut  = mux_in[laneSel*W +: W];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a row of count c yields lanes 0..min(c,32)-1 in order.
  task automatic pushExpected(input logic [W*32-1:0] d, input int c);
    int n;
    beat_t b;
    n = (c > 32) ? 32 : c;
    for (int k = 0; k < n; k++) begin
      b.word = d[k*W +: W];
      b.sel  = 5'(31 - k);
      b.last = (k == n - 1);
      expQ.push_back(b);
    end
  endtask

  // Monitor: pops on every fired beat and checks held outputs during stalls.
  initial begin
    logic [W-1:0] heldWord;
    logic [4:0]   heldSel;
    logic         heldLast;
    logic         holdPend;
    beat_t        e;
    holdPend = 1'b0;
    heldWord = '0;
    heldSel  = '0;
    heldLast = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (holdPend && !rst) begin
        checkOutput("hold_word", muxOut, heldWord);
        checkOutput("hold_sel", mux_sel, heldSel);
        checkOutput("hold_last", out_last, heldLast);
      end
      if (!rst && out_valid && out_ready) begin
        beatsSeen++;
        beatLog.push_back(cycle);
        if (expQ.size() == 0) begin
          checkOutput("extra_beat", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_word", muxOut, e.word);
          checkOutput("beat_sel", mux_sel, e.sel);
          checkOutput("beat_last", out_last, e.last);
        end
      end
      holdPend = !rst && out_valid && !out_ready;
      heldWord = muxOut;
      heldSel  = mux_sel;
      heldLast = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W*32-1:0] d, input int c, input int limit);
    bit accepted;
    int waited;
    accepted = 0;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_count = 6'(c);
    while (!accepted && waited < limit) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        pushExpected(d, c);
      end
      tick();
      waited++;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic waitBeats(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (beatsSeen < target && n < limit) begin
      tick();
      n++;
    end
    if (beatsSeen < target) checkOutput(name, beatsSeen, target);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    tick();
  endtask

  function automatic logic [W*32-1:0] randRow();
    logic [W*32-1:0] r;
    for (int k = 0; k < 32; k++) r[k*W +: W] = 16'($urandom);
    return r;
  endfunction

  initial begin
    logic [W*32-1:0] row;
    int base;
    int logStart;
    int pat[4];
    bit done;
    pat = '{1, 0, 0, 1};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_sel", mux_sel, 5'h1F);
    checkOutput("post_rst_mux_in", mux_in, 0);
    checkOutput("post_rst_last", out_last, 0);
    checkOutput("post_rst_valid", out_valid, 0);
    tick();

    // Full 32-lane row with ascending lane values
    for (int k = 0; k < 32; k++) row[k*W +: W] = 16'h0100 + 16'(k);
    base = beatsSeen;
    applyStimulus(row, 32, 50);
    waitBeats(base + 32, 100, "t1_beats_timeout");
    waitDrain(100);

    // Back-to-back rows with zero bubble, third row stalls
    base = beatsSeen;
    logStart = beatLog.size();
    applyStimulus(randRow(), 4, 50);
    applyStimulus(randRow(), 3, 50);
    in_valid = 1'b1;
    in_data  = randRow();
    in_count = 6'd2;
    @(negedge clk);
    checkOutput("t2_stall_in_ready", in_ready, 0);
    tick();
    applyStimulus(in_data, 2, 50);
    checkOutput("t2_stall_until_last", (beatsSeen - base) >= 4, 1);
    waitBeats(base + 9, 100, "t2_beats_timeout");
    if (beatLog.size() >= logStart + 7)
      checkOutput("t2_no_bubble", beatLog[logStart + 6] - beatLog[logStart], 6);
    else
      checkOutput("t2_beat_log", beatLog.size() - logStart, 7);
    waitDrain(100);

    // Consumer backpressure mid-row
    base = beatsSeen;
    applyStimulus(randRow(), 5, 50);
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i][0];
      tick();
    end
    out_ready = 1'b1;
    waitBeats(base + 5, 100, "t3_beats_timeout");
    repeat (5) tick();
    checkOutput("t3_beat_total", beatsSeen - base, 5);

    // Count 0 is dropped, count 40 clamps to a full row
    base = beatsSeen;
    applyStimulus(randRow(), 0, 50);
    @(negedge clk);
    checkOutput("t4_zero_busy", busy, 0);
    checkOutput("t4_zero_valid", out_valid, 0);
    repeat (3) tick();
    checkOutput("t4_zero_beats", beatsSeen - base, 0);
    applyStimulus(randRow(), 40, 50);
    waitBeats(base + 32, 100, "t4_beats_timeout");
    waitDrain(100);
    repeat (3) tick();
    checkOutput("t4_clamp_beats", beatsSeen - base, 32);

    // Reset mid-row with a second row queued
    base = beatsSeen;
    applyStimulus(randRow(), 32, 50);
    applyStimulus(randRow(), 32, 50);
    waitBeats(base + 10, 100, "t5_beats_timeout");
    rst = 1'b1;
    expQ.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid", out_valid, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_sel", mux_sel, 5'h1F);
    checkOutput("t5_beats_at_reset", beatsSeen - base, 10);
    tick();
    applyStimulus(randRow(), 6, 50);
    waitDrain(100);

    // Random valid/ready pressure
    done = 0;
    fork
      begin
        int c;
        int r;
        for (int n = 0; n < 200; n++) begin
          r = $urandom_range(0, 9);
          if (r == 0)      c = 0;
          else if (r == 1) c = $urandom_range(33, 63);
          else             c = $urandom_range(1, 32);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
          applyStimulus(randRow(), c, 2000);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    waitDrain(3000);
    repeat (20) tick();
    checkOutput("t6_scoreboard_empty", expQ.size(), 0);
    checkOutput("t6_final_busy", busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
